// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store controller: operation codes,
// FSM state encoding, UART address default and small decode helpers.
package lsu_mem_ctrl_pkg;

    localparam logic [5:0] ALU_NOP = 6'd0;
    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;
    localparam logic [5:0] ALU_SW  = 6'd27;

    localparam logic [31:0] UART_ADDR_DEFAULT = 32'hf6fff070;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_WAIT = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        RESP    = 3'd4
    } state_t;

    function automatic logic is_load(input logic [5:0] code);
        return (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) ||
               (code == ALU_LBU) || (code == ALU_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] code);
        return (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
    endfunction

    // Halfword accesses need bit 0 clear, word accesses need both low bits clear.
    function automatic logic is_misaligned(input logic [5:0] code, input logic [1:0] off);
        logic mis;
        case (code)
            ALU_LH, ALU_LHU, ALU_SH: mis = off[0];
            ALU_LW, ALU_SW:          mis = (off != 2'b00);
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_merge_extend.sv
// Combinational lane handling: extracts and extends a load lane from a
// RAM word, and inserts a store byte/halfword into a RAM word.
module lane_merge_extend
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [5:0]  code,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [15:0] lane_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte and halfword out of the word
    always_comb begin
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];
    end

    // Sign/zero extend according to the load flavour
    always_comb begin
        case (code)
            ALU_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
            ALU_LBU: load_data = {24'h0, byte_lane};
            ALU_LH:  load_data = {{16{half_lane[15]}}, half_lane};
            ALU_LHU: load_data = {16'h0, half_lane};
            ALU_LW:  load_data = word;
            default: load_data = 32'h0;
        endcase
    end

    // Replace the addressed lane with store data, keeping the other lanes
    always_comb begin
        merged = word;
        if (code == ALU_SB) begin
            case (offset)
                2'd0:    merged = {word[31:8], lane_data[7:0]};
                2'd1:    merged = {word[31:16], lane_data[7:0], word[7:0]};
                2'd2:    merged = {word[31:24], lane_data[7:0], word[15:0]};
                default: merged = {lane_data[7:0], word[23:0]};
            endcase
        end else if (code == ALU_SH) begin
            merged = offset[1] ? {lane_data, word[15:0]} : {word[31:16], lane_data};
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between execute and a word-wide block RAM.
// Byte/halfword stores are done as read-modify-write; byte/word stores to
// the UART address go to the UART port instead of RAM.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] UART_ADDR = UART_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        misalign,
    output logic [31:0] mem_r_addr,
    input  logic [31:0] mem_r_data,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data,
    output logic [5:0]  mem_wcode,
    output logic        uart_we,
    output logic [7:0]  uart_data
);

    state_t      state, state_next;
    logic [5:0]  code_q;
    logic [1:0]  off_q;
    logic [31:0] index_q;
    logic [15:0] wdata_q;
    logic [31:0] wword_q;
    logic        uart_q;

    logic        req_known, req_mis, req_uart;
    logic [31:0] load_data, merged;

    assign req_known = is_load(alucode) || is_store(alucode);
    assign req_mis   = is_misaligned(alucode, addr[1:0]);
    assign req_uart  = ((alucode == ALU_SB) || (alucode == ALU_SW)) &&
                       (addr == UART_ADDR) && !req_mis;

    // The RAM word always comes back in the cycle after the address, so the
    // lane logic works directly on mem_r_data with the latched request.
    lane_merge_extend u_lane (
        .code      (code_q),
        .offset    (off_q),
        .word      (mem_r_data),
        .lane_data (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    assign mem_w_addr = index_q;
    assign mem_w_data = wword_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and per-state strobes
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_wcode  = ALU_NOP;
        uart_we    = 1'b0;
        uart_data  = 8'h00;
        mem_r_addr = index_q;
        case (state)
            IDLE: begin
                req_ready  = 1'b1;
                mem_r_addr = {2'b00, addr[31:2]};
                if (req_valid) begin
                    if (!req_known || req_mis || req_uart) state_next = RESP;
                    else if (is_load(alucode))            state_next = LD_WAIT;
                    else if (alucode == ALU_SW)           state_next = ST_WR;
                    else                                  state_next = ST_RD;
                end
            end
            LD_WAIT: state_next = RESP;
            ST_RD:   state_next = ST_WR;
            ST_WR: begin
                mem_wcode  = ALU_SW;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                uart_we    = uart_q;
                uart_data  = uart_q ? wdata_q[7:0] : 8'h00;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, RMW word build-up and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= ALU_NOP;
            off_q    <= 2'b00;
            index_q  <= 32'h0;
            wdata_q  <= 16'h0;
            wword_q  <= 32'h0;
            uart_q   <= 1'b0;
            rsp_data <= 32'h0;
            misalign <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                code_q  <= alucode;
                off_q   <= addr[1:0];
                index_q <= {2'b00, addr[31:2]};
                wdata_q <= wdata[15:0];
                wword_q <= wdata;
                uart_q  <= req_uart;
            end
            if (state == ST_RD) wword_q <= merged;
            // Response registers change only when a new response is formed
            if (state_next == RESP && state != RESP) begin
                rsp_data <= (state == LD_WAIT) ? load_data : 32'h0;
                misalign <= (state == IDLE) && req_mis;
            end
        end
    end

endmodule
